// File: rtl/data_mem_seq_pkg.sv
// Shared definitions for the load/store byte sequencer: funct3 codes, FSM
// states and the per-request byte count.
package data_mem_seq_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [2:0] nbytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  // Unsigned widths exist only for loads; stores accept B/H/W alone.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_seq_if.sv
// CPU request/response port plus the byte-wide memory port of the sequencer.
interface data_mem_seq_if #(
  parameter int DATA_WIDTH = 32
);
  // A request transfers on a rising edge where req_valid && req_ready; the CPU
  // may change req_* freely while req_ready is low. resp_valid is a one-cycle
  // pulse with no back-pressure, and resp_rdata/resp_err hold until the next one.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic [1:0]            dbg_state;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_addr, mem_wd, dbg_state
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_we, mem_addr, mem_wd, dbg_state
  );
endinterface

// File: rtl/data_mem_seq_load_extend.sv
// Extends an assembled little-endian load word to full width according to funct3.
module load_extend
  import data_mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] ext
);

  always_comb begin
    ext = word;
    case (funct3)
      F3_B:    ext = {{(DATA_WIDTH-8){word[7]}}, word[7:0]};
      F3_H:    ext = {{(DATA_WIDTH-16){word[15]}}, word[15:0]};
      F3_BU:   ext = {{(DATA_WIDTH-8){1'b0}}, word[7:0]};
      F3_HU:   ext = {{(DATA_WIDTH-16){1'b0}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/data_mem_seq.sv
// Splits each CPU load/store into 1, 2 or 4 sequential byte accesses and
// returns one registered response per request.
module data_mem_seq
  import data_mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  data_mem_seq_if.slave bus
);

  state_t                state;
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [DATA_WIDTH-1:0] ext_word;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  we_q;
  logic                  err_q;
  logic [2:0]            f3_q;
  logic [1:0]            k;
  logic [1:0]            last_q;
  logic [BYTE_WIDTH-1:0] wbyte;
  logic                  unused_rd;

  // Only the low byte of the memory read bus carries data.
  assign unused_rd = ^bus.mem_rd[DATA_WIDTH-1:BYTE_WIDTH];

  // The final byte is merged combinationally so the response can be
  // registered on the same edge that reads it.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(k)*BYTE_WIDTH +: BYTE_WIDTH] = bus.mem_rd[BYTE_WIDTH-1:0];
  end

  assign wbyte = wdata_q[int'(k)*BYTE_WIDTH +: BYTE_WIDTH];

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .funct3 (f3_q),
    .word   (asm_next),
    .ext    (ext_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      k       <= '0;
      last_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            base_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            last_q  <= 2'(nbytes(bus.req_funct3) - 3'd1);
            k       <= '0;
            asm_q   <= '0;
            if (f3_legal(bus.req_we, bus.req_funct3)) begin
              state <= ACCESS;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= DONE;
            end
          end
        end
        ACCESS: begin
          if (!we_q) asm_q <= asm_next;
          k <= k + 2'd1;
          if (k == last_q) begin
            rdata_q <= we_q ? '0 : ext_word;
            err_q   <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_we     = (state == ACCESS) && we_q;
  assign bus.mem_addr   = (state == ACCESS) ? base_q + DATA_WIDTH'(k) : '0;
  assign bus.mem_wd     = ((state == ACCESS) && we_q) ? DATA_WIDTH'(wbyte) : '0;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_data_mem_seq.sv
// Bench for data_mem_seq: a 256-byte memory window at 0x1_0000 plus a
// transaction-level model of the byte memory and load extension.
module tb_data_mem_seq;
  import data_mem_seq_pkg::*;

  localparam logic [31:0] WIN_BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] dev_mem  [0:255];
  logic [7:0] init_img [0:255];
  logic [7:0] ref_mem  [0:255];

  data_mem_seq_if #(.DATA_WIDTH(32)) bus ();

  data_mem_seq #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset / memory device ----------------
  always #5 clk = ~clk;

  function automatic logic in_win(input logic [31:0] a);
    return (a >> 8) == (WIN_BASE >> 8);
  endfunction

  assign bus.mem_rd = in_win(bus.mem_addr) ? {24'h0, dev_mem[bus.mem_addr[7:0]]} : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_img[i];
    end else if (bus.mem_we && in_win(bus.mem_addr)) begin
      dev_mem[bus.mem_addr[7:0]] <= bus.mem_wd[7:0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int nb_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic legal(input logic we, input logic [2:0] f3);
    if (we) return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2;
    return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return in_win(a) ? ref_mem[a[7:0]] : 8'h00;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [7:0] b);
    if (in_win(a)) ref_mem[a[7:0]] = b;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [63:0] v;
    int n;
    n = nb_of(f3);
    v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_byte(addr + 32'(i))) << (8 * i));
    if ((f3 == F3_B || f3 == F3_H) && v[8*n-1]) v = v - (64'h1 << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic scramble();
    bus.req_valid  = 1'($urandom_range(0, 1));
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic rand_req(output logic we, output logic [2:0] f3,
                          output logic [31:0] addr, output logic [31:0] wdata);
    we    = 1'($urandom_range(0, 1));
    f3    = 3'($urandom_range(0, 7));
    wdata = $urandom;
    if ($urandom_range(0, 9) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    else addr = WIN_BASE + 32'($urandom_range(0, 255));
  endtask

  // Issues one request from IDLE and checks every cycle until the response.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got);
    logic ok;
    int n;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    ok = legal(we, f3);
    n = nb_of(f3);
    exp_rd = (ok && !we) ? model_load(f3, addr) : 32'h0;
    check("ready_idle", 96'(bus.req_ready), 96'(1'b1));
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    scramble();
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        exp_wd = we ? {24'h0, wdata[8*i +: 8]} : 32'h0;
        check("access", 96'({bus.resp_valid, bus.req_ready, bus.mem_we, bus.mem_addr,
                             (we ? bus.mem_wd : 32'h0)}),
                        96'({1'b0, 1'b0, we, addr + 32'(i), exp_wd}));
        @(negedge clk);
        scramble();
      end
      if (we) for (int i = 0; i < n; i++) ref_wr(addr + 32'(i), wdata[8*i +: 8]);
    end
    check("resp", 96'({bus.resp_valid, bus.req_ready, bus.mem_we, bus.resp_err, bus.resp_rdata}),
                  96'({1'b1, 1'b0, 1'b0, !ok, exp_rd}));
    got = bus.resp_rdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("resp_hold", 96'({bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata}),
                       96'({1'b0, 1'b1, !ok, exp_rd}));
  endtask

  // req_valid held high with a fresh request every cycle; the model decides
  // which ones are accepted and when each response is due.
  task automatic stream_phase(input int cycles);
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata;
    int busy_left, pre, accepts, resps;
    busy_left = 0; accepts = 0; resps = 0;
    for (int c = 0; c < cycles + 6; c++) begin
      @(negedge clk);
      pre = busy_left;
      check("strm_hs", 96'({bus.req_ready, bus.resp_valid}), 96'({pre == 0, pre == 1}));
      if (bus.resp_valid) resps++;
      if (pre == 1) begin
        e = exp_q.pop_front();
        check("strm_resp", 96'({bus.resp_err, bus.resp_rdata}), 96'(e));
      end
      if (c >= cycles) begin
        bus.req_valid = 1'b0;
        if (pre > 0) busy_left = pre - 1;
      end else begin
        rand_req(we, f3, addr, wdata);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        if (pre > 0) begin
          busy_left = pre - 1;
        end else begin
          accepts++;
          if (!legal(we, f3)) begin
            exp_q.push_back({1'b1, 32'h0});
            busy_left = 1;
          end else begin
            exp_q.push_back({1'b0, (we ? 32'h0 : model_load(f3, addr))});
            if (we) for (int i = 0; i < nb_of(f3); i++) ref_wr(addr + 32'(i), wdata[8*i +: 8]);
            busy_left = nb_of(f3) + 1;
          end
        end
      end
    end
    check("strm_count", 96'(resps), 96'(accepts));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata, raddr;
    logic [7:0] b;

    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      init_img[i] = b;
      ref_mem[i] = b;
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'h0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset", 96'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we, bus.resp_rdata}),
                   96'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
    check("reset_mem", 96'({bus.mem_addr, bus.mem_wd}), 96'(64'h0));
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // directed: full-word store then every load width over it
    run_req(1'b1, F3_W, 32'h0001_0000, 32'hDEAD_BEEF, got);
    run_req(1'b0, F3_W, 32'h0001_0000, 32'h0, got);
    check("lw_const", 96'(got), 96'(32'hDEAD_BEEF));
    run_req(1'b0, F3_H, 32'h0001_0002, 32'h0, got);
    check("lh_const", 96'(got), 96'(32'hFFFF_DEAD));
    run_req(1'b0, F3_HU, 32'h0001_0002, 32'h0, got);
    check("lhu_const", 96'(got), 96'(32'h0000_DEAD));
    run_req(1'b0, F3_B, 32'h0001_0001, 32'h0, got);
    check("lb_const", 96'(got), 96'(32'hFFFF_FFBE));
    run_req(1'b0, F3_BU, 32'h0001_0001, 32'h0, got);
    check("lbu_const", 96'(got), 96'(32'h0000_00BE));

    // misaligned halfword store straddling a word boundary
    run_req(1'b1, F3_H, 32'h0001_0003, 32'h0000_1234, got);
    run_req(1'b0, F3_W, 32'h0001_0001, 32'h0, got);
    check("mis_lw_const", 96'(got), 96'(32'h1234_ADBE));

    // illegal codes: one-cycle error response, no memory traffic
    run_req(1'b0, 3'b011, 32'h0001_0010, 32'h0, got);
    run_req(1'b1, 3'b100, 32'h0001_0010, 32'h5555_AAAA, got);
    run_req(1'b1, 3'b101, 32'h0001_0010, 32'h5555_AAAA, got);
    run_req(1'b0, 3'b111, 32'h0001_0010, 32'h0, got);

    // address wrap past 0xFFFF_FFFF and out-of-window access
    run_req(1'b1, F3_W, 32'hFFFF_FFFE, 32'h0102_0304, got);
    run_req(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, got);
    run_req(1'b0, F3_W, 32'h0001_00FE, 32'h0, got);

    for (int i = 0; i < 40; i++) begin
      rand_req(we, f3, addr, wdata);
      run_req(we, f3, addr, wdata, got);
    end

    stream_phase(300);

    // reset in the middle of a word store, after two bytes were written
    raddr = WIN_BASE + 32'h20;
    wdata = $urandom;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = raddr; bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_abort", 96'({bus.mem_we, bus.resp_valid, bus.req_ready, bus.mem_addr, bus.mem_wd}),
                       96'({1'b0, 1'b0, 1'b1, 64'h0}));
    check("rst_resp_regs", 96'({bus.resp_err, bus.resp_rdata}), 96'(33'h0));
    ref_wr(raddr, wdata[7:0]);
    ref_wr(raddr + 32'd1, wdata[15:8]);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_noresp", 96'({bus.resp_valid, bus.mem_we}), 96'(2'b00));
    end
    for (int i = 0; i < 4; i++)
      check("rst_bytes", 96'(dev_mem[8'h20 + 8'(i)]), 96'(ref_mem[8'h20 + 8'(i)]));
    run_req(1'b0, F3_W, raddr, 32'h0, got);
    run_req(1'b1, F3_B, raddr + 32'd3, 32'h0000_0077, got);
    run_req(1'b0, F3_W, raddr, 32'h0, got);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_seq.md
Name: data_mem_seq

Overview:
- Sequencer between the CPU load/store port and the byte-wide data memory. The memory does one byte per cycle: combinational read, write on the clock edge.
- Converts each LB/LH/LW/LBU/LHU/SB/SH/SW request into 1, 2 or 4 consecutive byte accesses.
- Assembles and extends read data, returns one response per request.
- The CPU stalls on req_ready/resp_valid.

Parameters:
- DATA_WIDTH, 32, width of CPU data and memory address/data buses.
- BYTE_WIDTH, 8, width of one memory location.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU presents a memory request.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 width/sign code.
- req_addr  in  DATA_WIDTH  byte address of lowest byte.
- req_wdata  in  DATA_WIDTH  store data, little-endian.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: illegal funct3.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_WIDTH  memory byte address.
- mem_wd  out  DATA_WIDTH  write byte in [7:0], upper bits 0.
- mem_rd  in  DATA_WIDTH  read byte in [7:0], combinational from mem_addr.

Behaviour:
- Reset, asynchronous on rst high:
  - State goes to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - Byte counter and all latches are cleared.
- States:
  - IDLE → ACCESS on accept.
  - IDLE → DONE on an illegal request.
  - ACCESS → DONE after the last byte.
  - DONE → IDLE unconditionally.
- Accept:
  - A request is accepted on a rising edge with req_valid && req_ready. req_ready=1 only in IDLE.
  - On accept, latch addr, we, funct3 and wdata.
  - Set N: funct3[1:0] = 00 → 1, 01 → 2, 10 → 4.
  - Clear the byte counter k=0.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Any other code goes to DONE with no memory access; resp_err=1 and resp_rdata=0.
- ACCESS, driven combinationally from registered state:
  - mem_addr = base + k, modulo 2^32 (wraps past 0xFFFF_FFFF).
  - Store: mem_we=1, mem_wd[7:0] = wdata byte k.
  - Load: mem_we=0, and at the clock edge capture mem_rd[7:0] into assembly byte k.
  - k increments each cycle; the last cycle is k = N-1.
- Outside ACCESS: mem_we=0, mem_addr=0, mem_wd=0.
- DONE:
  - resp_valid=1 for exactly one cycle.
  - Loads return the assembled value extended from bit 8N-1: sign-extended for 000/001, zero-extended for 100/101, unmodified for LW.
  - Stores return resp_rdata=0, resp_err=0.
  - resp_rdata and resp_err are registered and held until the next response; resp_valid is 0 outside DONE.
- Latency:
  - Accept to resp_valid is N+1 cycles: LB 2, LH 3, LW 5.
  - Illegal request: 1 cycle.
  - Throughput is one request per N+2 cycles; no new accept in the DONE cycle.
- Misaligned addresses are legal: bytes are simply sequential, with no alignment check.
- Out-of-window addresses are passed through unchanged. The memory returns 0 and ignores the write; the sequencer does not flag this.
- While busy, req_* inputs are ignored, so the CPU may change them.
- Reset mid-operation: abort immediately. mem_we drops asynchronously and no response is issued. Bytes already written stay written (partial store is accepted behaviour).

Decomposition:
- Package data_mem_seq_pkg holds:
  - funct3 localparams: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum state_t {IDLE, ACCESS, DONE}.
  - Function nbytes(funct3) returning 1/2/4.
- One sub-module, load_extend: combinational, funct3 plus a 32-bit assembled word in, extended word out. It is reusable by a future pipelined memory stage.

Test Plan:
- After reset, SW addr=0x0001_0000, wdata=0xDEAD_BEEF → 4 cycles with mem_we=1, addresses 0x10000..0x10003 carrying bytes EF, BE, AD, DE, then resp_valid at cycle 5, resp_err=0.
- LW 0x0001_0000 following that store → resp_rdata=0xDEAD_BEEF; LH 0x0001_0002 → 0xFFFF_DEAD; LHU → 0x0000_DEAD; LB 0x0001_0001 → 0xFFFF_FFBE; LBU → 0x0000_00BE.
- Misaligned: SH addr=0x0001_0003, wdata=0x1234 → bytes 34@0x10003, 12@0x10004; LW 0x0001_0001 → 0x1234_ADBE.
- Illegal: load with funct3=011 and store with funct3=100 → resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0, mem_we never asserted.
- Handshake: hold req_valid high continuously with a different request each cycle → req_ready low while busy, each request accepted only in IDLE, exactly one resp_valid per accept.
- Reset mid-SW (rst pulse after byte 1 written) → mem_we=0 immediately, no resp_valid, bytes 0–1 changed and bytes 2–3 untouched, next request serviced normally.
